// File: rtl/led_phy_tx_pkg.sv
// Shared types and helpers for the LED one-wire transmitter.
// LED_GAMMA_EN selects gamma-2.2 LUT expansion instead of nibble replication.
package led_pkg;

  localparam int LED_WORD_W = 12;
  localparam int LED_BITS   = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    BIT   = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } led_tx_state_t;

`ifdef LED_GAMMA_EN
  localparam logic [7:0] GAMMA_LUT [16] = '{
    8'd0,   8'd1,   8'd3,   8'd7,   8'd14,  8'd23,  8'd34,  8'd48,
    8'd64,  8'd83,  8'd105, 8'd129, 8'd156, 8'd186, 8'd219, 8'd255
  };
`endif

  function automatic logic [7:0] expand4to8(input logic [3:0] x);
`ifdef LED_GAMMA_EN
    return GAMMA_LUT[x];
`else
    return {x, x};
`endif
  endfunction

endpackage

// File: rtl/led_phy_tx_if.sv
// Frame control and FIFO-read bundle between the fill FSM, the FIFO and the transmitter.
// slave = transmitter side, master = FIFO / fill-FSM side.
interface led_phy_tx_if;
  import led_pkg::*;

  logic                  send_start;
  logic                  fifo_empty;
  logic                  fifo_rd;
  logic [LED_WORD_W-1:0] fifo_rdata;
  logic                  led_dout;
  logic                  busy;
  logic                  done;
  logic                  underflow;

  modport slave (
    input  send_start, fifo_empty, fifo_rdata,
    output fifo_rd, led_dout, busy, done, underflow
  );

  modport master (
    output send_start, fifo_empty, fifo_rdata,
    input  fifo_rd, led_dout, busy, done, underflow
  );

endinterface

// File: rtl/led_phy_tx_bit.sv
// Single NRZ bit timer: high for T1H/T0H cycles of a TBIT-cycle slot.
// Latency: dout valid in the first run cycle after start; bit_done in the last slot cycle.
// Backpressure: none, free-running while run is high.
module led_bit_tx #(
  parameter int TBIT_CYC = 63,
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic run,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int CW = $clog2(TBIT_CYC);

  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] high_cyc;

  assign high_cyc = bit_val ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign dout     = run && (cyc_cnt < high_cyc);
  assign bit_done = run && (cyc_cnt == CW'(TBIT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt <= '0;
    end else if (start) begin
      cyc_cnt <= '0;
    end else if (run) begin
      cyc_cnt <= bit_done ? '0 : cyc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_phy_tx.sv
// Reads LED_NUM {B,G,R} words from the frame FIFO and drives a GRB MSB-first one-wire stream, then latches low.
// Latency: fifo_rd 1 cycle after send_start, first led_dout rise 3 cycles after; 2-cycle gap between LEDs.
// Backpressure: an empty FIFO ends the frame early with sticky underflow; send_start while busy is dropped.
module led_phy_tx
  import led_pkg::*;
#(
  parameter int LED_NUM  = 47,
  parameter int TBIT_CYC = 63,
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int TRST_CYC = 2500
) (
  input  logic            clk,
  input  logic            rstn,
  led_phy_tx_if.slave     bus
);

  if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
    $error("led_phy_tx: bit timing must satisfy T0H_CYC < T1H_CYC < TBIT_CYC");
  end

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_FETCH = 3'(FETCH);
  localparam logic [2:0] S_LOAD  = 3'(LOAD);
  localparam logic [2:0] S_BIT   = 3'(BIT);
  localparam logic [2:0] S_LATCH = 3'(LATCH);
  localparam logic [2:0] S_DONE  = 3'(DONE);

  localparam int BW  = $clog2(LED_BITS);
  localparam int LCW = $clog2(LED_NUM + 1);
  localparam int RCW = $clog2(TRST_CYC + 1);

  logic [2:0]          state;
  logic [LED_BITS-1:0] sr;
  logic [BW-1:0]       bit_idx;
  logic [LCW-1:0]      led_cnt;
  logic [RCW-1:0]      lat_cnt;
  logic                underflow_q;
  logic                bit_dout;
  logic                bit_done;

  led_bit_tx #(
    .TBIT_CYC (TBIT_CYC),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC)
  ) u_bit (
    .clk      (clk),
    .rstn     (rstn),
    .start    (state == S_LOAD),
    .run      (state == S_BIT),
    .bit_val  (sr[LED_BITS-1]),
    .dout     (bit_dout),
    .bit_done (bit_done)
  );

  // Outputs decode straight from state so an async reset drops the line immediately.
  assign bus.fifo_rd   = (state == S_FETCH) && !bus.fifo_empty;
  assign bus.led_dout  = bit_dout;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.underflow = underflow_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      sr          <= '0;
      bit_idx     <= '0;
      led_cnt     <= '0;
      lat_cnt     <= '0;
      underflow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.send_start) begin
            state       <= S_FETCH;
            underflow_q <= 1'b0;
            led_cnt     <= '0;
          end
        end
        S_FETCH: begin
          if (bus.fifo_empty) begin
            state       <= S_LATCH;
            underflow_q <= 1'b1;
            lat_cnt     <= '0;
          end else begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Wire order is GRB; the FIFO word is packed {B,G,R}.
          sr      <= {expand4to8(bus.fifo_rdata[7:4]),
                      expand4to8(bus.fifo_rdata[3:0]),
                      expand4to8(bus.fifo_rdata[11:8])};
          bit_idx <= '0;
          state   <= S_BIT;
        end
        S_BIT: begin
          if (bit_done) begin
            sr      <= {sr[LED_BITS-2:0], 1'b0};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BW'(LED_BITS - 1)) begin
              bit_idx <= '0;
              led_cnt <= led_cnt + 1'b1;
              if (led_cnt == LCW'(LED_NUM - 1)) begin
                state   <= S_LATCH;
                lat_cnt <= '0;
              end else begin
                state <= S_FETCH;
              end
            end
          end
        end
        S_LATCH: begin
          if (lat_cnt == RCW'(TRST_CYC - 1)) begin
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_phy_tx.sv
// Directed-random bench for led_phy_tx with a FIFO model and a waveform-level reference.
module tb_led_phy_tx;

  localparam int LN   = 2;
  localparam int TBIT = 6;
  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TRST = 10;
  localparam int BUDGET = 1000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  led_phy_tx_if ifc ();

  led_phy_tx #(
    .LED_NUM  (LN),
    .TBIT_CYC (TBIT),
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .TRST_CYC (TRST)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc.slave)
  );

  // FIFO model: bench pushes via wr_ptr, DUT reads advance rd_ptr, data one cycle after fifo_rd.
  logic [11:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ifc.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (ifc.fifo_rd && (rd_ptr < wr_ptr)) begin
      ifc.fifo_rdata <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  bit rec_dout[$];
  bit rec_done[$];
  bit rec_rd[$];
  int rd_when_empty;
  bit exp_dout[$];
  int exp_rd;
  int exp_uf;
  int gamma_tab[16] = '{0, 1, 3, 7, 14, 23, 34, 48, 64, 83, 105, 129, 156, 186, 219, 255};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp8(input int x);
`ifdef LED_GAMMA_EN
    return gamma_tab[x];
`else
    return x * 17;
`endif
  endfunction

  task automatic push(input logic [11:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Expected line level per cycle, starting the cycle after send_start is sampled.
  task automatic build_exp();
    int avail;
    exp_dout.delete();
    exp_rd = 0;
    exp_uf = 0;
    avail  = wr_ptr - rd_ptr;
    for (int led = 0; led < LN; led++) begin
      if (led < avail) begin
        int w;
        int grb;
        w   = int'(mem[rd_ptr + led]);
        grb = (exp8((w >> 4) & 15) << 16) | (exp8(w & 15) << 8) | exp8((w >> 8) & 15);
        exp_rd++;
        exp_dout.push_back(1'b0);
        exp_dout.push_back(1'b0);
        for (int b = 23; b >= 0; b--) begin
          int hi;
          hi = ((grb >> b) & 1) ? T1H : T0H;
          for (int c = 0; c < TBIT; c++) exp_dout.push_back(c < hi);
        end
      end else begin
        exp_dout.push_back(1'b0);
        exp_uf = 1;
        break;
      end
    end
    for (int c = 0; c < TRST + 1; c++) exp_dout.push_back(1'b0);
  endtask

  task automatic run_frame(input int restart_at);
    int i;
    rec_dout.delete();
    rec_done.delete();
    rec_rd.delete();
    rd_when_empty = 0;
    @(negedge clk);
    ifc.send_start = 1'b1;
    @(negedge clk);
    ifc.send_start = 1'b0;
    for (i = 0; i < BUDGET; i++) begin
      rec_dout.push_back(ifc.led_dout);
      rec_done.push_back(ifc.done);
      rec_rd.push_back(ifc.fifo_rd);
      if (ifc.fifo_rd && ifc.fifo_empty) rd_when_empty++;
      ifc.send_start = (i == restart_at);
      if (ifc.done) break;
      @(negedge clk);
    end
    ifc.send_start = 1'b0;
    check("frame_done_within_budget", int'(i < BUDGET), 1);
  endtask

  task automatic check_frame(input string name);
    int mism;
    int ndone;
    int nrd;
    mism  = 0;
    ndone = 0;
    nrd   = 0;
    for (int i = 0; i < rec_dout.size() && i < exp_dout.size(); i++)
      if (rec_dout[i] !== exp_dout[i]) mism++;
    foreach (rec_done[i]) ndone += int'(rec_done[i]);
    foreach (rec_rd[i]) nrd += int'(rec_rd[i]);
    check({name, "_wave_len"}, rec_dout.size(), exp_dout.size());
    check({name, "_wave_mismatches"}, mism, 0);
    check({name, "_done_pulses"}, ndone, 1);
    check({name, "_fifo_reads"}, nrd, exp_rd);
    check({name, "_rd_while_empty"}, rd_when_empty, 0);
    check({name, "_underflow"}, int'(ifc.underflow), exp_uf);
    @(negedge clk);
    check({name, "_busy_after_done"}, int'(ifc.busy), 0);
  endtask

  initial begin
    int first_rd;
    int rises[$];
    int found;

    rstn = 1'b0;
    ifc.send_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fifo_rd", int'(ifc.fifo_rd), 0);
    check("rst_led_dout", int'(ifc.led_dout), 0);
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_done", int'(ifc.done), 0);
    check("rst_underflow", int'(ifc.underflow), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frame: R=F on LED 1, B=F on LED 2.
    push(12'h00F);
    push(12'hF00);
    build_exp();
    run_frame(-1);
    first_rd = -1;
    foreach (rec_rd[i]) if (rec_rd[i] && first_rd < 0) first_rd = i;
    rises.delete();
    foreach (rec_dout[i]) if (rec_dout[i] && (i == 0 || !rec_dout[i-1])) rises.push_back(i);
    check("lat_first_fifo_rd", first_rd, 0);
    check("lat_first_rise", (rises.size() > 0) ? rises[0] : -1, 2);
    check("gap_led1_b23_to_led2_b0", (rises.size() > 24) ? rises[24] - rises[23] : -1, TBIT + 2);
    check_frame("directed");

    // Random words, extra send_start mid-frame, one word left behind.
    push(12'($urandom));
    push(12'($urandom));
    push(12'($urandom));
    build_exp();
    run_frame(30);
    check_frame("restart_ignored");
    check("leftover_words", wr_ptr - rd_ptr, 1);

    // Only one word available: second FETCH underflows.
    build_exp();
    run_frame(-1);
    check_frame("underflow");
    repeat (5) @(negedge clk);
    check("underflow_sticky", int'(ifc.underflow), 1);

    push(12'($urandom));
    push(12'($urandom));
    build_exp();
    run_frame(-1);
    check_frame("after_underflow");

    // Abort mid-bit with the line high.
    push(12'hFFF);
    push(12'($urandom));
    @(negedge clk);
    ifc.send_start = 1'b1;
    @(negedge clk);
    ifc.send_start = 1'b0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (i >= 8 && ifc.led_dout) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_found_high", found, 1);
    rstn = 1'b0;
    #1;
    check("abort_led_dout", int'(ifc.led_dout), 0);
    check("abort_busy", int'(ifc.busy), 0);
    check("abort_fifo_rd", int'(ifc.fifo_rd), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push(12'($urandom));
    build_exp();
    run_frame(-1);
    check_frame("after_abort");

    // Mid-scale on every channel: replication gives 0x88, gamma gives 0x40.
    while (wr_ptr != rd_ptr) begin
      build_exp();
      run_frame(-1);
      check_frame("drain");
    end
    push(12'h888);
    push(12'h888);
    build_exp();
    run_frame(-1);
    check_frame("mid_scale");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
